// File: rtl/conv_sequencer_pkg.sv
// rtl/conv_sequencer_pkg.sv - shared geometry constants and FSM state type for conv_sequencer
//
// Package conv_pkg: default frame geometry (IMG_W, KER, PIX_W), the derived
// OFM_W / POOL_W sizes and the sequencer state enum.
package conv_pkg;

  localparam int IMG_W  = 14;
  localparam int KER    = 3;
  localparam int PIX_W  = 16;
  localparam int OFM_W  = IMG_W - KER + 1;
  localparam int POOL_W = OFM_W / 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FILL,
    RUN,
    POOL,
    DONE
  } state_t;

endpackage

// File: rtl/conv_sequencer_if.sv
// rtl/conv_sequencer_if.sv - source/window/pool handshake bundle for conv_sequencer
//
// Signals:
//   src_valid / src_ready  - IFM pixel/weight beat handshake
//   wgt_wr_en / wgt_idx    - weight slot write strobe and slot 0..8
//   pix_shift              - window buffer shift strobe
//   win_valid / ofm_addr   - valid 3x3 window and its OFM address
//   pool_valid / pool_ready / pool_base - 2x2 pool request handshake
// Modports: master (sequencer side), slave (source / buffer / pool side).
interface conv_sequencer_if;

  logic       src_valid;
  logic       src_ready;
  logic       wgt_wr_en;
  logic [3:0] wgt_idx;
  logic       pix_shift;
  logic       win_valid;
  logic [7:0] ofm_addr;
  logic       pool_valid;
  logic       pool_ready;
  logic [7:0] pool_base;

  modport master (
    input  src_valid, pool_ready,
    output src_ready, wgt_wr_en, wgt_idx, pix_shift,
           win_valid, ofm_addr, pool_valid, pool_base
  );

  modport slave (
    output src_valid, pool_ready,
    input  src_ready, wgt_wr_en, wgt_idx, pix_shift,
           win_valid, ofm_addr, pool_valid, pool_base
  );

endinterface

// File: rtl/conv_sequencer_pos_cnt.sv
// rtl/conv_sequencer_pos_cnt.sv - pixel row/col position counter with registered window flag
//
// Module conv_pos_cnt. Ports:
//   clk       - rising-edge clock
//   rst       - synchronous reset, active high
//   clr       - synchronous clear between frames
//   en        - one pixel accepted this cycle
//   win_valid - registered: previous accepted pixel completed a full window
//   ofm_addr  - registered OFM address of that window
module conv_pos_cnt #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int KER   = conv_pkg::KER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic       win_valid,
  output logic [7:0] ofm_addr
);

  localparam int CW    = $clog2(IMG_W);
  localparam int OFM_W = IMG_W - KER + 1;
  localparam logic [CW-1:0] EDGE = CW'(KER - 1);
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);

  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          in_win;

  // Columns/rows below KER-1 cannot be the bottom-right corner of a window.
  assign in_win = (row >= EDGE) && (col >= EDGE);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      ofm_addr  <= '0;
    end else begin
      win_valid <= en && in_win;
      if (en) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (in_win) begin
          ofm_addr <= 8'(row - EDGE) * 8'(OFM_W) + 8'(col - EDGE);
        end
      end
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - convolution frame sequencer (weights, pixel windows, pool requests)
//
// One frame: KER*KER weight beats, IMG_W*IMG_W pixel beats producing
// registered window-valid pulses with OFM addresses, then (optionally)
// OFM_W/2 x OFM_W/2 row-major 2x2 pool requests.
// Build option CONV_SEQ_POOL_EN: POOL state present; when undefined the
// frame ends right after the last pixel, pool_valid/pool_base are 0 and
// pool_ready has no effect.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous reset, active high
//   start - frame start pulse, only honoured in IDLE
//   busy  - high in every state except IDLE
//   done  - one-cycle end-of-frame pulse
//   bus   - conv_sequencer_if.master handshake bundle
module conv_sequencer #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int KER   = conv_pkg::KER,
  parameter int PIX_W = conv_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  conv_sequencer_if.master  bus
);

  // Beat-count values (count before increment) of the last beat per phase.
  localparam logic [7:0] LAST_WGT  = 8'(KER * KER - 1);
  localparam logic [7:0] LAST_FILL = 8'((KER - 1) * IMG_W + KER - 1);
  localparam logic [7:0] LAST_PIX  = 8'(IMG_W * IMG_W - 1);

  // No pixel data passes through the sequencer; PIX_W only sizes the
  // datapath it controls.
  localparam int unused_pix_w = PIX_W;

  conv_pkg::state_t state;
  conv_pkg::state_t state_nx;
  logic [7:0]       beat_cnt;
  logic             pix_en;
  logic             accept;

  assign accept = bus.src_valid && bus.src_ready;

`ifdef CONV_SEQ_POOL_EN
  localparam int OFM_W  = IMG_W - KER + 1;
  localparam int POOL_W = OFM_W / 2;
  localparam int PW     = (POOL_W > 1) ? $clog2(POOL_W) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(POOL_W - 1);

  logic [PW-1:0] pr;
  logic [PW-1:0] pc;
  logic          pool_last;

  assign pool_last = (pr == P_LAST) && (pc == P_LAST);

  always_ff @(posedge clk) begin
    if (rst_n || state == conv_pkg::IDLE) begin
      pr <= '0;
      pc <= '0;
    end else if (state == conv_pkg::POOL && bus.pool_ready) begin
      if (pc == P_LAST) begin
        pc <= '0;
        pr <= pr + 1'b1;
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

  assign bus.pool_valid = (state == conv_pkg::POOL);
  assign bus.pool_base  = (state == conv_pkg::POOL)
                        ? 8'(pr) * 8'(2 * OFM_W) + 8'({pc, 1'b0})
                        : '0;
`else
  // pool_ready has no effect in this build.
  logic unused_pool_ready;
  assign unused_pool_ready = bus.pool_ready;
  assign bus.pool_valid    = 1'b0;
  assign bus.pool_base     = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= conv_pkg::IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Pixel beats count on from 0 after the weights so FILL and RUN share one count.
  always_ff @(posedge clk) begin
    if (rst_n || state == conv_pkg::IDLE ||
        (state == conv_pkg::LOAD_W && state_nx == conv_pkg::FILL)) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.src_ready = 1'b0;
    bus.wgt_wr_en = 1'b0;
    pix_en        = 1'b0;
    unique case (state)
      conv_pkg::IDLE: begin
        if (start) state_nx = conv_pkg::LOAD_W;
      end
      conv_pkg::LOAD_W: begin
        bus.src_ready = 1'b1;
        bus.wgt_wr_en = bus.src_valid;
        if (bus.src_valid && beat_cnt == LAST_WGT) state_nx = conv_pkg::FILL;
      end
      conv_pkg::FILL: begin
        bus.src_ready = 1'b1;
        pix_en        = bus.src_valid;
        if (bus.src_valid && beat_cnt == LAST_FILL) state_nx = conv_pkg::RUN;
      end
      conv_pkg::RUN: begin
        bus.src_ready = 1'b1;
        pix_en        = bus.src_valid;
        if (bus.src_valid && beat_cnt == LAST_PIX) begin
`ifdef CONV_SEQ_POOL_EN
          state_nx = conv_pkg::POOL;
`else
          state_nx = conv_pkg::DONE;
`endif
        end
      end
      conv_pkg::POOL: begin
`ifdef CONV_SEQ_POOL_EN
        if (bus.pool_ready && pool_last) state_nx = conv_pkg::DONE;
`else
        state_nx = conv_pkg::DONE;
`endif
      end
      conv_pkg::DONE: begin
        state_nx = conv_pkg::IDLE;
      end
      default: begin
        state_nx = conv_pkg::IDLE;
      end
    endcase
  end

  assign bus.pix_shift = pix_en;
  assign bus.wgt_idx   = (state == conv_pkg::LOAD_W) ? beat_cnt[3:0] : 4'd0;
  assign busy          = (state != conv_pkg::IDLE);
  assign done          = (state == conv_pkg::DONE);

  conv_pos_cnt #(
    .IMG_W (IMG_W),
    .KER   (KER)
  ) u_pos_cnt (
    .clk       (clk),
    .rst       (rst_n),
    .clr       (state == conv_pkg::IDLE),
    .en        (pix_en),
    .win_valid (bus.win_valid),
    .ofm_addr  (bus.ofm_addr)
  );

endmodule
